// File: rtl/fpadd_rr_scheduler_if.sv
// fpadd_rr_scheduler_if: request, classifier, adder and result signals of the shared fp-add scheduler.
interface fpadd_rr_scheduler_if;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] cls_a, cls_b, cls_s;
    logic cls_enable;
    logic dp_start, dp_done;
    logic [31:0] dp_a, dp_b, dp_sum;
    logic res_valid, res_ready, res_id, res_err;
    logic [31:0] res_data;
    modport slave (
        input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input cls_enable, cls_s, dp_done, dp_sum, res_ready,
        output req0_ready, req1_ready, cls_a, cls_b, dp_start, dp_a, dp_b,
        output res_valid, res_id, res_data, res_err
    );
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output cls_enable, cls_s, dp_done, dp_sum, res_ready,
        input req0_ready, req1_ready, cls_a, cls_b, dp_start, dp_a, dp_b,
        input res_valid, res_id, res_data, res_err
    );
endinterface

// File: rtl/fpadd_rr_scheduler.sv
// fpadd_rr_scheduler: round-robin sharing of one fp adder between two requesters.
// Define FPADD_TIMEOUT_EN to add a watchdog that answers a quiet NaN when EXEC stalls.
module fpadd_rr_scheduler #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W = 8
) (
    input logic clk,
    input logic rst,
    fpadd_rr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLASSIFY, EXEC, RESP} state_t;
    state_t state, stateNext;
    logic prio, grant, granting, timeout;
    logic [31:0] opA, opB, resData;
    logic resId, resErr;

    if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : badTimeoutWidth
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef FPADD_TIMEOUT_EN
    logic [TO_W-1:0] toCnt;
    always_ff @(posedge clk)
        toCnt <= (rst || state != EXEC) ? '0 : toCnt + 1'b1;
    assign timeout = state == EXEC && toCnt == TO_W'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // Ready implies the granted requester is valid, so ready alone marks an accept.
    assign grant = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    assign granting = !rst && state == IDLE && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = granting && !grant;
    assign bus.req1_ready = granting && grant;
    assign bus.cls_a = opA;
    assign bus.cls_b = opB;
    assign bus.dp_a = opA;
    assign bus.dp_b = opB;
    assign bus.dp_start = state == CLASSIFY && bus.cls_enable;
    assign bus.res_valid = state == RESP;
    assign bus.res_data = resData;
    assign bus.res_id = resId;
    assign bus.res_err = resErr;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = granting ? CLASSIFY : IDLE;
            CLASSIFY: stateNext = bus.cls_enable ? EXEC : RESP;
            EXEC: stateNext = (bus.dp_done || timeout) ? RESP : EXEC;
            RESP: stateNext = bus.res_ready ? IDLE : RESP;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio <= 1'b0;
            opA <= '0;
            opB <= '0;
            resData <= '0;
            resId <= 1'b0;
            resErr <= 1'b0;
        end else begin
            state <= stateNext;
            if (granting) begin
                opA <= grant ? bus.req1_a : bus.req0_a;
                opB <= grant ? bus.req1_b : bus.req0_b;
                resId <= grant;
                prio <= !grant;
            end
            if (state == CLASSIFY && !bus.cls_enable) begin
                resData <= bus.cls_s;
                resErr <= 1'b0;
            end
            // A done arriving on the expiry cycle takes precedence over the watchdog.
            if (state == EXEC && bus.dp_done) begin
                resData <= bus.dp_sum;
                resErr <= 1'b0;
            end else if (timeout) begin
                resData <= 32'h7FC00000;
                resErr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fpadd_rr_scheduler.sv
// tb_fpadd_rr_scheduler: directed and randomized checks of the round-robin fp-add scheduler
// against a queue-based reference model, with behavioural classifier and adder.
module tb_fpadd_rr_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpadd_rr_scheduler_if bus();
    fpadd_rr_scheduler #(.TIMEOUT_CYCLES(16), .TO_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nChecks = 0;
    int nFails = 0;
    int doneDelay = 3;
    bit adderOn = 1'b1;

    function automatic bit isSpecial(logic [31:0] x);
        return x[30:0] == 31'd0 || x[30:23] == 8'hFF;
    endfunction

    function automatic logic [31:0] clsResult(logic [31:0] a, logic [31:0] b);
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:0] == 31'd0) return b;
        return a;
    endfunction

    function automatic logic [31:0] sumModel(logic [31:0] a, logic [31:0] b);
        return (a == 32'h3FC00000 && b == 32'h40200000) ? 32'h40800000 : a + b;
    endfunction

    function automatic logic [31:0] expectResult(logic [31:0] a, logic [31:0] b);
        return (isSpecial(a) || isSpecial(b)) ? clsResult(a, b) : sumModel(a, b);
    endfunction

    function automatic logic [31:0] randOp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return {r[31], 31'h7F800000};
            2: return {r[31], 9'h1FF, r[22:0]};
            3: return {r[31], 8'h00, r[22:1], 1'b1};
            default: return {r[31], 1'b0, r[29:23] | 7'h01, r[22:0]};
        endcase
    endfunction

    assign bus.cls_enable = !isSpecial(bus.cls_a) && !isSpecial(bus.cls_b);
    assign bus.cls_s = clsResult(bus.cls_a, bus.cls_b);

    // Adder: done pulse doneDelay cycles after the start cycle.
    initial begin
        bus.dp_done = 1'b0;
        bus.dp_sum = '0;
        forever begin
            @(negedge clk);
            if (bus.dp_start && adderOn) begin
                logic [31:0] s;
                s = sumModel(bus.dp_a, bus.dp_b);
                repeat (doneDelay) @(posedge clk);
                #1 bus.dp_done = 1'b1;
                bus.dp_sum = s;
                @(posedge clk);
                #1 bus.dp_done = 1'b0;
                bus.dp_sum = $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        tick();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++; if (bus.req0_ready !== 1'b0) begin nFails++; $display("FAIL reset_ready0 got %b want 0", bus.req0_ready); end
        nChecks++; if (bus.req1_ready !== 1'b0) begin nFails++; $display("FAIL reset_ready1 got %b want 0", bus.req1_ready); end
        nChecks++; if (bus.res_valid !== 1'b0) begin nFails++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        nChecks++; if (bus.dp_start !== 1'b0) begin nFails++; $display("FAIL reset_dp_start got %b want 0", bus.dp_start); end
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        nChecks++; if (bus.cls_a !== 32'd0 || bus.cls_b !== 32'd0) begin nFails++; $display("FAIL reset_ops got %h/%h want 0/0", bus.cls_a, bus.cls_b); end
        nChecks++; if (bus.res_data !== 32'd0 || bus.res_id !== 1'b0 || bus.res_err !== 1'b0) begin nFails++; $display("FAIL reset_res got %h/%b/%b want 0/0/0", bus.res_data, bus.res_id, bus.res_err); end
    endtask

    task automatic test_special();
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_a = 32'h00000000;
        bus.req0_b = 32'h3FC00000;
        @(negedge clk);
        nChecks++; if (bus.req0_ready !== 1'b1) begin nFails++; $display("FAIL special_accept got %b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        nChecks++; if (bus.dp_start !== 1'b0 || bus.res_valid !== 1'b0) begin nFails++; $display("FAIL special_cycle1 dp_start=%b res_valid=%b want 0/0", bus.dp_start, bus.res_valid); end
        nChecks++; if (bus.cls_b !== 32'h3FC00000) begin nFails++; $display("FAIL special_cls_b got %h want 3fc00000", bus.cls_b); end
        tick();
        @(negedge clk);
        nChecks++; if (bus.res_valid !== 1'b1) begin nFails++; $display("FAIL special_latency res_valid got %b want 1", bus.res_valid); end
        nChecks++; if (bus.res_data !== 32'h3FC00000 || bus.res_id !== 1'b0 || bus.res_err !== 1'b0) begin nFails++; $display("FAIL special_result got %h/%b/%b want 3fc00000/0/0", bus.res_data, bus.res_id, bus.res_err); end
        tick();
        @(negedge clk);
        nChecks++; if (bus.res_valid !== 1'b0) begin nFails++; $display("FAIL special_consumed res_valid got %b want 0", bus.res_valid); end
    endtask

    task automatic test_normal();
        int starts = 0;
        int lat = 0;
        bit seen = 1'b0;
        bit moved = 1'b0;
        doneDelay = 3;
        tick();
        bus.req1_valid = 1'b1;
        bus.req1_a = 32'h3FC00000;
        bus.req1_b = 32'h40200000;
        @(negedge clk);
        nChecks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin nFails++; $display("FAIL normal_accept ready1=%b ready0=%b want 1/0", bus.req1_ready, bus.req0_ready); end
        tick();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        nChecks++; if (bus.dp_start !== 1'b1) begin nFails++; $display("FAIL normal_dp_start got %b want 1", bus.dp_start); end
        nChecks++; if (bus.dp_a !== 32'h3FC00000 || bus.dp_b !== 32'h40200000) begin nFails++; $display("FAIL normal_dp_ops got %h/%h want 3fc00000/40200000", bus.dp_a, bus.dp_b); end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            @(negedge clk);
            lat++;
            if (bus.dp_start) starts++;
            if (bus.dp_a !== 32'h3FC00000 || bus.dp_b !== 32'h40200000) moved = 1'b1;
            if (bus.res_valid) seen = 1'b1;
        end
        nChecks++; if (lat !== 4) begin nFails++; $display("FAIL normal_latency got %0d cycles want 4 (seen=%b)", lat, seen); end
        nChecks++; if (starts !== 0) begin nFails++; $display("FAIL normal_extra_starts got %0d want 0", starts); end
        nChecks++; if (moved !== 1'b0) begin nFails++; $display("FAIL normal_ops_stable got changed want stable"); end
        nChecks++; if (bus.res_data !== 32'h40800000 || bus.res_id !== 1'b1 || bus.res_err !== 1'b0) begin nFails++; $display("FAIL normal_result got %h/%b/%b want 40800000/1/0", bus.res_data, bus.res_id, bus.res_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        int order[$];
        int ids[$];
        int both = 0;
        bit acc0, acc1;
        doReset();
        bus.res_ready = 1'b1;
        doneDelay = 2;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_a = randOp(); bus.req0_b = randOp();
        bus.req1_a = randOp(); bus.req1_b = randOp();
        for (int c = 0; c < 200 && ids.size() < 4; c++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) both++;
            if (bus.res_valid) ids.push_back(int'(bus.res_id));
            acc0 = bus.req0_ready;
            acc1 = bus.req1_ready;
            if (acc0 || acc1) order.push_back(int'(acc1));
            tick();
            if (acc0) begin bus.req0_a = randOp(); bus.req0_b = randOp(); end
            if (acc1) begin bus.req1_a = randOp(); bus.req1_b = randOp(); end
        end
        nChecks++; if (both !== 0) begin nFails++; $display("FAIL b2b_both_ready got %0d cycles want 0", both); end
        nChecks++; if (ids.size() < 4) begin nFails++; $display("FAIL b2b_results got %0d want 4", ids.size()); end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            nChecks++; if (order[i] !== i % 2) begin nFails++; $display("FAIL b2b_grant[%0d] got %0d want %0d", i, order[i], i % 2); end
        end
        for (int i = 0; i < 4 && i < ids.size(); i++) begin
            nChecks++; if (ids[i] !== i % 2) begin nFails++; $display("FAIL b2b_res_id[%0d] got %0d want %0d", i, ids[i], i % 2); end
        end
        drain();
    endtask

    task automatic test_stall();
        bus.res_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_a = 32'h00000000;
        bus.req0_b = 32'h40000000;
        @(negedge clk);
        nChecks++; if (bus.req0_ready !== 1'b1) begin nFails++; $display("FAIL stall_accept got %b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_a = 32'h00000000;
        bus.req1_b = 32'h00000000;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            nChecks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h40000000 || bus.res_id !== 1'b0) begin nFails++; $display("FAIL stall_hold[%0d] got %b/%h/%b want 1/40000000/0", k, bus.res_valid, bus.res_data, bus.res_id); end
            nChecks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin nFails++; $display("FAIL stall_ready[%0d] got %b/%b want 0/0", k, bus.req0_ready, bus.req1_ready); end
        end
        tick();
        bus.res_ready = 1'b1;
        @(negedge clk);
        nChecks++; if (bus.res_valid !== 1'b1) begin nFails++; $display("FAIL stall_release res_valid got %b want 1", bus.res_valid); end
        tick();
        @(negedge clk);
        nChecks++; if (bus.res_valid !== 1'b0 || bus.req1_ready !== 1'b1) begin nFails++; $display("FAIL stall_idle res_valid=%b ready1=%b want 0/1", bus.res_valid, bus.req1_ready); end
        drain();
    endtask

    task automatic test_reset_exec();
        int hits = 0;
        int gotId[$];
        logic [31:0] gotData[$];
        bit acc1;
        doneDelay = 4;
        bus.res_ready = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_a = 32'h3F800000;
        bus.req0_b = 32'h40000000;
        @(negedge clk);
        nChecks++; if (bus.req0_ready !== 1'b1) begin nFails++; $display("FAIL rexec_accept got %b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        nChecks++; if (bus.dp_start !== 1'b1) begin nFails++; $display("FAIL rexec_start got %b want 1", bus.dp_start); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.res_valid) hits++;
            tick();
        end
        nChecks++; if (hits !== 0) begin nFails++; $display("FAIL rexec_no_result got %0d valid cycles want 0", hits); end
        nChecks++; if (bus.cls_a !== 32'd0) begin nFails++; $display("FAIL rexec_op_cleared got %h want 0", bus.cls_a); end
        bus.req0_valid = 1'b1;
        bus.req0_a = 32'h3F800000;
        bus.req0_b = 32'h3F800000;
        bus.req1_valid = 1'b1;
        bus.req1_a = 32'h00000000;
        bus.req1_b = 32'h7F800000;
        @(negedge clk);
        nChecks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin nFails++; $display("FAIL rexec_prio ready0=%b ready1=%b want 1/0", bus.req0_ready, bus.req1_ready); end
        tick();
        bus.req0_valid = 1'b0;
        for (int c = 0; c < 60 && gotId.size() < 2; c++) begin
            @(negedge clk);
            acc1 = bus.req1_ready;
            if (bus.res_valid) begin gotId.push_back(int'(bus.res_id)); gotData.push_back(bus.res_data); end
            tick();
            if (acc1) bus.req1_valid = 1'b0;
        end
        nChecks++; if (gotId.size() !== 2) begin nFails++; $display("FAIL rexec_results got %0d want 2", gotId.size()); end
        if (gotId.size() == 2) begin
            nChecks++; if (gotId[0] !== 0 || gotData[0] !== 32'h7F000000) begin nFails++; $display("FAIL rexec_first got %0d/%h want 0/7f000000", gotId[0], gotData[0]); end
            nChecks++; if (gotId[1] !== 1 || gotData[1] !== 32'h7F800000) begin nFails++; $display("FAIL rexec_second got %0d/%h want 1/7f800000", gotId[1], gotData[1]); end
        end
        drain();
    endtask

    task automatic test_random();
        int left[2];
        logic [31:0] expData[$];
        int expId[$];
        bit prioM = 1'b0;
        bit acc0, acc1, v0, v1;
        int expGrant, id, both;
        logic [31:0] d;
        left[0] = 30;
        left[1] = 30;
        both = 0;
        acc0 = 1'b0;
        acc1 = 1'b0;
        doReset();
        for (int c = 0; c < 5000 && (left[0] > 0 || left[1] > 0 || bus.req0_valid || bus.req1_valid || expData.size() > 0); c++) begin
            if (acc0) bus.req0_valid = 1'b0;
            if (acc1) bus.req1_valid = 1'b0;
            if (!bus.req0_valid && left[0] > 0 && $urandom_range(0, 2) == 0) begin
                bus.req0_valid = 1'b1; bus.req0_a = randOp(); bus.req0_b = randOp(); left[0]--;
            end
            if (!bus.req1_valid && left[1] > 0 && $urandom_range(0, 2) == 0) begin
                bus.req1_valid = 1'b1; bus.req1_a = randOp(); bus.req1_b = randOp(); left[1]--;
            end
            bus.res_ready = 1'($urandom_range(0, 1));
            doneDelay = $urandom_range(1, 4);
            @(negedge clk);
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            acc0 = bus.req0_ready;
            acc1 = bus.req1_ready;
            if (acc0 && acc1) both++;
            if (acc0 || acc1) begin
                id = int'(acc1);
                expGrant = (v0 && v1) ? int'(prioM) : int'(v1);
                nChecks++; if (id !== expGrant) begin nFails++; $display("FAIL rand_grant got %0d want %0d", id, expGrant); end
                expId.push_back(id);
                expData.push_back(acc1 ? expectResult(bus.req1_a, bus.req1_b) : expectResult(bus.req0_a, bus.req0_b));
                prioM = !acc1;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (expData.size() == 0) begin
                    nChecks++; nFails++; $display("FAIL rand_spurious got result %h want none", bus.res_data);
                end else begin
                    d = expData.pop_front();
                    id = expId.pop_front();
                    nChecks++; if (bus.res_data !== d || int'(bus.res_id) !== id || bus.res_err !== 1'b0) begin nFails++; $display("FAIL rand_result got %h/%b/%b want %h/%0d/0", bus.res_data, bus.res_id, bus.res_err, d, id); end
                end
            end
            tick();
        end
        nChecks++; if (both !== 0) begin nFails++; $display("FAIL rand_both_ready got %0d want 0", both); end
        nChecks++; if (left[0] + left[1] + expData.size() !== 0) begin nFails++; $display("FAIL rand_incomplete got %0d pending want 0", left[0] + left[1] + expData.size()); end
        drain();
    endtask

`ifdef FPADD_TIMEOUT_EN
    task automatic test_timeout();
        int lat = 0;
        bit seen = 1'b0;
        adderOn = 1'b0;
        bus.res_ready = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_a = 32'h3F800000;
        bus.req0_b = 32'h40400000;
        @(negedge clk);
        nChecks++; if (bus.req0_ready !== 1'b1) begin nFails++; $display("FAIL timeout_accept got %b want 1", bus.req0_ready); end
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        nChecks++; if (bus.dp_start !== 1'b1) begin nFails++; $display("FAIL timeout_start got %b want 1", bus.dp_start); end
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            @(negedge clk);
            lat++;
            if (bus.res_valid) seen = 1'b1;
        end
        nChecks++; if (lat !== 17) begin nFails++; $display("FAIL timeout_latency got %0d want 17 (seen=%b)", lat, seen); end
        nChecks++; if (bus.res_data !== 32'h7FC00000 || bus.res_err !== 1'b1 || bus.res_id !== 1'b0) begin nFails++; $display("FAIL timeout_result got %h/%b/%b want 7fc00000/1/0", bus.res_data, bus.res_err, bus.res_id); end
        tick();
        adderOn = 1'b1;
        drain();
    endtask
`endif

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req1_a = '0;
        bus.req1_b = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_special();
        test_normal();
        test_back_to_back();
        test_stall();
        test_reset_exec();
        test_random();
`ifdef FPADD_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
